// File: rtl/fifo_rd_packer.sv
// Read-domain consumer for the dual-clock byte FIFO: pops entries and packs PACK of them
// little-endian into one output word with valid/ready handshake and flush-with-keep support.
module fifo_rd_packer #(
  parameter  int DSIZE = 8,
  parameter  int PACK  = 4,
  localparam int OSIZE = DSIZE * PACK
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             flush,
  output logic [OSIZE-1:0] odata,
  output logic [PACK-1:0]  okeep,
  output logic             ovalid,
  input  logic             oready,
  output logic             busy
);

  localparam int            CW   = $clog2(PACK);
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);

  logic [CW-1:0]    r_cnt;
  logic [OSIZE-1:0] r_acc;
  logic             r_flush_pend;
  logic [OSIZE-1:0] r_odata;
  logic [PACK-1:0]  r_okeep;
  logic             r_ovalid;

  logic             w_out_free;
  logic             w_pop;
  logic             w_emit;
  logic [OSIZE-1:0] w_acc_merged;
  logic [CW:0]      w_fill;
  logic [PACK-1:0]  w_keep;

  assign w_out_free = !r_ovalid || oready;
  // The last lane may only be filled when the output register can take the word.
  assign w_pop  = !rrst && !rempty && ((r_cnt != LAST) || w_out_free);
  assign w_emit = w_out_free &&
                  ((w_pop && (r_cnt == LAST)) ||
                   (r_flush_pend && ((r_cnt != '0) || w_pop)));

  always_comb begin
    w_acc_merged = r_acc;
    if (w_pop) begin
      w_acc_merged[int'(r_cnt) * DSIZE +: DSIZE] = rdata;
    end
  end

  assign w_fill = {1'b0, r_cnt} + {{CW{1'b0}}, w_pop};

  always_comb begin
    w_keep = '0;
    for (int k = 0; k < PACK; k++) begin
      w_keep[k] = (k < int'(w_fill));
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_flush_pend <= 1'b0;
      r_odata      <= '0;
      r_okeep      <= '0;
      r_ovalid     <= 1'b0;
    end else begin
      if (w_emit) begin
        r_cnt   <= '0;
        r_acc   <= '0;
        r_odata <= w_acc_merged;
        r_okeep <= w_keep;
      end else if (w_pop) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_merged;
      end

      if (w_emit) begin
        r_ovalid <= 1'b1;
      end else if (r_ovalid && oready) begin
        r_ovalid <= 1'b0;
      end

      // A pending flush with nothing buffered retires silently.
      if (w_emit) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end else if (r_flush_pend && (r_cnt == '0) && !w_pop) begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  assign rinc   = w_pop;
  assign odata  = r_odata;
  assign okeep  = r_okeep;
  assign ovalid = r_ovalid;
  assign busy   = (r_cnt != '0) || r_ovalid || r_flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed vector table, hand-written corner sequences, and a
// randomized run scored against a byte-stream reference of a behavioural FIFO.
module tb_fifo_rd_packer;

  logic        rclk;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] odata;
  logic [3:0]  okeep;
  logic        ovalid;
  logic        oready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  bit          prev_stall = 0;
  logic [31:0] prev_d;
  logic [3:0]  prev_k;

  // fmode: 0 no flush, 1 flush together with the last pop, 2 flush pulse after the pops
  typedef struct {
    int          n;
    logic [31:0] bytes;
    int          fmode;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
  } vec_t;

  vec_t vt[5];

  fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
    .rclk   (rclk),
    .rrst   (rrst),
    .rdata  (rdata),
    .rempty (rempty),
    .rinc   (rinc),
    .flush  (flush),
    .odata  (odata),
    .okeep  (okeep),
    .ovalid (ovalid),
    .oready (oready),
    .busy   (busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit keep_ok(logic [3:0] k);
    logic [4:0] kp;
    kp = {1'b0, k} + 5'd1;
    return (k != 4'd0) && ((kp[3:0] & k) == 4'd0);
  endfunction

  task automatic observe();
    chk("no_pop_when_empty", 32'(rinc & rempty), 32'd0);
    if (rrst) chk("rinc_in_reset", 32'(rinc), 32'd0);
    if (prev_stall) begin
      chk("hold_valid", 32'(ovalid), 32'd1);
      chk("hold_data", odata, prev_d);
      chk("hold_keep", 32'(okeep), 32'(prev_k));
    end
    if (ovalid && oready && !rrst) begin
      chk("keep_shape", 32'(keep_ok(okeep)), 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (okeep[k]) rx_q.push_back(odata[k*8 +: 8]);
      end
    end
    prev_stall = ovalid && !oready && !rrst;
    prev_d = odata;
    prev_k = okeep;
  endtask

  task automatic tick(input bit rst, input bit emp, input logic [7:0] d, input bit fl, input bit rdy);
    @(negedge rclk);
    rrst = rst; rempty = emp; rdata = d; flush = fl; oready = rdy;
    #1;
    observe();
  endtask

  task automatic feed_cycle(input bit rdy, input bit stall_en, input bit fl);
    bit emp;
    logic [7:0] d;
    emp = (src_q.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
    d = (src_q.size() != 0) ? src_q[0] : 8'h00;
    tick(0, emp, d, fl, rdy);
    if (rinc) exp_q.push_back(src_q.pop_front());
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [31:0] b;
    bit seen;
    b = v.bytes;
    for (int j = 0; j < v.n; j++) begin
      tick(0, 0, b[j*8 +: 8], (v.fmode == 1) && (j == v.n - 1), 1);
      chk({nm, "_pop"}, 32'(rinc), 32'd1);
    end
    if (v.fmode == 2) tick(0, 1, 8'h00, 1, 1);
    seen = 0;
    for (int t = 0; t < 6 && !seen; t++) begin
      tick(0, 1, 8'h00, 0, 1);
      seen = ovalid;
    end
    chk({nm, "_valid"}, 32'(seen), 32'd1);
    chk({nm, "_data"}, odata, v.exp_d);
    chk({nm, "_keep"}, 32'(okeep), 32'(v.exp_k));
    tick(0, 1, 8'h00, 0, 1);
    chk({nm, "_one_cycle"}, 32'(ovalid), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n_mis;
    int budget;

    vt[0] = '{n: 4, bytes: 32'h44332211, fmode: 0, exp_d: 32'h44332211, exp_k: 4'b1111};
    vt[1] = '{n: 2, bytes: 32'h0000BBAA, fmode: 2, exp_d: 32'h0000BBAA, exp_k: 4'b0011};
    vt[2] = '{n: 1, bytes: 32'h0000005C, fmode: 2, exp_d: 32'h0000005C, exp_k: 4'b0001};
    vt[3] = '{n: 3, bytes: 32'h00A3A2A1, fmode: 1, exp_d: 32'h00A3A2A1, exp_k: 4'b0111};
    vt[4] = '{n: 4, bytes: 32'hEFBEADDE, fmode: 1, exp_d: 32'hEFBEADDE, exp_k: 4'b1111};

    rrst = 1; rempty = 0; rdata = 8'h5A; flush = 0; oready = 1;

    // Reset with data available: nothing may be popped.
    tick(1, 0, 8'h5A, 0, 1);
    tick(1, 0, 8'h5A, 0, 1);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_okeep", 32'(okeep), 32'd0);
    chk("rst_odata", odata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(0, 1, 8'h00, 0, 1);

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Flush with nothing buffered: no word, busy falls back.
    tick(0, 1, 8'h00, 1, 1);
    tick(0, 1, 8'h00, 0, 1);
    chk("flush0_novalid_a", 32'(ovalid), 32'd0);
    tick(0, 1, 8'h00, 0, 1);
    chk("flush0_novalid_b", 32'(ovalid), 32'd0);
    tick(0, 1, 8'h00, 0, 1);
    chk("flush0_busy", 32'(busy), 32'd0);

    // Backpressure: two words, output stalled.
    rx_q.delete(); exp_q.delete(); src_q.delete();
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    for (int i = 0; i < 10; i++) feed_cycle(0, 0, 0);
    chk("bp_pops", exp_q.size(), 7);
    chk("bp_stall_rinc", 32'(rinc), 32'd0);
    chk("bp_word1_valid", 32'(ovalid), 32'd1);
    chk("bp_word1", odata, 32'h04030201);
    chk("bp_word1_keep", 32'(okeep), 32'hF);
    feed_cycle(1, 0, 0);
    feed_cycle(1, 0, 0);
    chk("bp_word2_valid", 32'(ovalid), 32'd1);
    chk("bp_word2", odata, 32'h08070605);
    tick(0, 1, 8'h00, 0, 1);
    chk("bp_rx_count", rx_q.size(), 8);
    n_mis = 0;
    for (int i = 0; i < rx_q.size() && i < 8; i++) if (rx_q[i] !== 8'(i + 1)) n_mis++;
    chk("bp_rx_bytes", n_mis, 0);

    // Reset mid-word while an output word is held.
    src_q.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) src_q.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 10; i++) feed_cycle(0, 0, 0);
    chk("mid_held_valid", 32'(ovalid), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    tick(1, 0, 8'h99, 0, 0);
    tick(0, 1, 8'h00, 0, 1);
    chk("mid_rst_ovalid", 32'(ovalid), 32'd0);
    chk("mid_rst_okeep", 32'(okeep), 32'd0);
    chk("mid_rst_odata", odata, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    src_q.delete();
    run_vec('{n: 4, bytes: 32'hC4C3C2C1, fmode: 0, exp_d: 32'hC4C3C2C1, exp_k: 4'hF}, "post_rst");

    // Randomized: random empty gaps, random ready, occasional flushes.
    rx_q.delete(); exp_q.delete(); src_q.delete();
    for (int i = 0; i < 150; i++) src_q.push_back(8'($urandom));
    budget = 0;
    while (src_q.size() != 0 && budget < 3000) begin
      feed_cycle($urandom_range(0, 2) != 0, 1, $urandom_range(0, 19) == 0);
      budget++;
    end
    chk("rand_src_drained", src_q.size(), 0);
    feed_cycle(1, 0, 1);
    for (int i = 0; i < 8; i++) feed_cycle(1, 0, 0);
    chk("rand_idle", 32'(busy), 32'd0);
    chk("rand_count", rx_q.size(), exp_q.size());
    n_mis = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) n_mis++;
    chk("rand_bytes", n_mis, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
